// File: rtl/bus_arbiter.sv
// CPU-priority arbiter sharing the core memory bus with a buffered master-1 port, plus RAM/MMIO decode.
// Defining ARB_STATS_EN adds m1_wait_cnt, a saturating count of cycles a held master-1 request is blocked.
module bus_arbiter #(
    parameter logic [63:0] RAM_BASE  = 64'h0000_0000_8000_0000,
    parameter logic [63:0] RAM_SIZE  = 64'h0000_0000_0010_0000,
    parameter logic [63:0] MMIO_BASE = 64'h0000_0000_1000_0000,
    parameter logic [63:0] MMIO_SIZE = 64'h0000_0000_0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] cpu_addr,
    input  logic [63:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [63:0] cpu_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [63:0] m1_addr,
    input  logic [63:0] m1_wdata,
    output logic        m1_ready,
    output logic        m1_done,
    output logic        m1_err,
    output logic [63:0] m1_rdata,
    output logic [63:0] ram_addr,
    output logic [63:0] ram_wdata,
    output logic        ram_we,
    output logic        ram_re,
    input  logic [63:0] ram_rdata,
    output logic [63:0] mmio_addr,
    output logic [63:0] mmio_wdata,
    output logic        mmio_we,
    output logic        mmio_re,
    input  logic [63:0] mmio_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [31:0] m1_wait_cnt
`endif
);

    typedef enum logic [2:0] {
        OWN_NONE,
        OWN_CPU_RAM,
        OWN_CPU_MMIO,
        OWN_CPU_UNMAPPED,
        OWN_M1_RAM,
        OWN_M1_MMIO,
        OWN_M1_UNMAPPED
    } owner_e;

    owner_e      owner_q, owner_d;
    logic        hold_valid_q, hold_valid_d;
    logic        hold_we_q;
    logic [63:0] hold_addr_q, hold_wdata_q;
    logic        cpu_act, issue_m1, accept;
    logic [63:0] sel_addr, sel_wdata;
    logic        sel_we, sel_re, hit_ram, hit_mmio;

    // The window end is formed in 65 bits so a region touching the top of the map cannot wrap.
    function automatic logic in_window(input logic [63:0] addr, input logic [63:0] base,
                                       input logic [63:0] size);
        logic [64:0] end_x;
        end_x = {1'b0, base} + {1'b0, size};
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < end_x);
    endfunction

    assign m1_ready = ~hold_valid_q;
    assign accept   = m1_req & m1_ready;

    always_comb begin
        cpu_act   = cpu_re | cpu_we;
        issue_m1  = hold_valid_q & ~cpu_act;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        sel_we    = cpu_we;
        sel_re    = cpu_re & ~cpu_we;
        if (!cpu_act) begin
            sel_addr  = hold_addr_q;
            sel_wdata = hold_wdata_q;
            sel_we    = issue_m1 & hold_we_q;
            sel_re    = issue_m1 & ~hold_we_q;
        end
        hit_ram  = in_window(sel_addr, RAM_BASE, RAM_SIZE);
        hit_mmio = in_window(sel_addr, MMIO_BASE, MMIO_SIZE);

        hold_valid_d = hold_valid_q;
        if (accept) begin
            hold_valid_d = 1'b1;
        end else if (issue_m1) begin
            hold_valid_d = 1'b0;
        end

        owner_d = OWN_NONE;
        if (cpu_act) begin
            if (hit_ram)       owner_d = OWN_CPU_RAM;
            else if (hit_mmio) owner_d = OWN_CPU_MMIO;
            else               owner_d = OWN_CPU_UNMAPPED;
        end else if (issue_m1) begin
            if (hit_ram)       owner_d = OWN_M1_RAM;
            else if (hit_mmio) owner_d = OWN_M1_MMIO;
            else               owner_d = OWN_M1_UNMAPPED;
        end
    end

    // Strobes are gated by reset directly so they drop the instant reset asserts.
    assign ram_addr   = sel_addr;
    assign ram_wdata  = sel_wdata;
    assign ram_we     = reset & hit_ram & sel_we;
    assign ram_re     = reset & hit_ram & sel_re;
    assign mmio_addr  = sel_addr;
    assign mmio_wdata = sel_wdata;
    assign mmio_we    = reset & hit_mmio & sel_we;
    assign mmio_re    = reset & hit_mmio & sel_re;

    always_comb begin
        cpu_rdata = '0;
        m1_rdata  = '0;
        m1_done   = 1'b0;
        m1_err    = 1'b0;
        case (owner_q)
            OWN_CPU_RAM:  cpu_rdata = ram_rdata;
            OWN_CPU_MMIO: cpu_rdata = mmio_rdata;
            OWN_M1_RAM: begin
                m1_rdata = ram_rdata;
                m1_done  = 1'b1;
            end
            OWN_M1_MMIO: begin
                m1_rdata = mmio_rdata;
                m1_done  = 1'b1;
            end
            OWN_M1_UNMAPPED: begin
                m1_done = 1'b1;
                m1_err  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q      <= OWN_NONE;
            hold_valid_q <= 1'b0;
            hold_we_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
        end else begin
            owner_q      <= owner_d;
            hold_valid_q <= hold_valid_d;
            if (accept) begin
                hold_we_q    <= m1_we;
                hold_addr_q  <= m1_addr;
                hold_wdata_q <= m1_wdata;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] wait_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else if (hold_valid_q && cpu_act && (wait_cnt_q != 32'hFFFF_FFFF)) begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
        end
    end

    assign m1_wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: behavioural RAM/MMIO slaves and a response scoreboard.
// Build with ARB_STATS_EN defined to also cover m1_wait_cnt.
module tb_bus_arbiter;

    localparam logic [63:0] K_RAM  = 64'h5A5A_0000_0000_0000;
    localparam logic [63:0] K_MMIO = 64'h0000_C3C3_0000_0000;
    localparam logic [63:0] BAD    = 64'hBAD0_BAD0_BAD0_BAD0;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_we, cpu_re;
    logic        m1_req, m1_we, m1_ready, m1_done, m1_err;
    logic [63:0] m1_addr, m1_wdata, m1_rdata;
    logic [63:0] ram_addr, ram_wdata, mmio_addr, mmio_wdata;
    logic        ram_we, ram_re, mmio_we, mmio_re;
    logic [63:0] ram_rdata  = '0;
    logic [63:0] mmio_rdata = '0;
`ifdef ARB_STATS_EN
    logic [31:0] m1_wait_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] cpu_exp_q[$];
    logic [63:0] m1_exp_q[$];
    logic [63:0] ram_mem[logic [63:0]];
    logic [63:0] mmio_mem[logic [63:0]];

    bus_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_rdata(cpu_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
        .ram_rdata(ram_rdata),
        .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_we(mmio_we), .mmio_re(mmio_re),
        .mmio_rdata(mmio_rdata)
`ifdef ARB_STATS_EN
        , .m1_wait_cnt(m1_wait_cnt)
`endif
    );

    // Clock: 10-unit period; inputs change 1 unit after the rising edge.
    always #5 clk = ~clk;

    function automatic logic [63:0] ram_read(input logic [63:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        if (a == 64'h8000_0010) return 64'hDEAD_BEEF;
        return a ^ K_RAM;
    endfunction

    function automatic logic [63:0] mmio_read(input logic [63:0] a);
        if (mmio_mem.exists(a)) return mmio_mem[a];
        return a ^ K_MMIO;
    endfunction

    // Slaves: 1-cycle read latency; data bus shows garbage when not read so misrouting is visible.
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] = ram_wdata;
        if (mmio_we) mmio_mem[mmio_addr] = mmio_wdata;
        ram_rdata  <= ram_re ? ram_read(ram_addr) : BAD;
        mmio_rdata <= mmio_re ? mmio_read(mmio_addr) : BAD;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_cpu_resp(input string tag);
        logic [63:0] e;
        if (cpu_exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed empty cpu scoreboard expected an entry", tag);
        end else begin
            e = cpu_exp_q.pop_front();
            chk(tag, cpu_rdata, e);
        end
    endtask

    task automatic chk_m1_resp(input string tag);
        logic [63:0] e;
        chk1({tag, "_done"}, m1_done, 1'b1);
        chk1({tag, "_err"}, m1_err, 1'b0);
        if (m1_exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed empty m1 scoreboard expected an entry", tag);
        end else begin
            e = m1_exp_q.pop_front();
            chk(tag, m1_rdata, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic re, input logic we, input logic [63:0] a, input logic [63:0] d);
        cpu_re    = re;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    task automatic m1_drive(input logic req, input logic we, input logic [63:0] a, input logic [63:0] d);
        m1_req   = req;
        m1_we    = we;
        m1_addr  = a;
        m1_wdata = d;
    endtask

    function automatic logic [3:0] strobes();
        return {ram_we, ram_re, mmio_we, mmio_re};
    endfunction

    logic [63:0] bnd_addr[7] = '{64'h8000_0000, 64'h800F_FFF8, 64'h8010_0000, 64'h7FFF_FFF8,
                                 64'h1000_0FF8, 64'h1000_1000, 64'hFFFF_FFFF_FFFF_FFF8};
    logic [3:0]  bnd_exp[7]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};

    initial begin
        // Reset with a CPU read already asserted: strobes must stay low.
        reset = 1'b0;
        cpu_drive(1'b1, 1'b0, 64'h8000_0010, '0);
        m1_drive(1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_strobes", 64'(strobes()), 64'h0);
        chk1("rst_m1_ready", m1_ready, 1'b1);
        chk1("rst_m1_done", m1_done, 1'b0);
        chk1("rst_m1_err", m1_err, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 64'h0);
        chk("rst_m1_rdata", m1_rdata, 64'h0);
`ifdef ARB_STATS_EN
        chk("rst_wait_cnt", 64'(m1_wait_cnt), 64'd0);
`endif
        cpu_drive(1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        tick();

        // CPU RAM read.
        cpu_drive(1'b1, 1'b0, 64'h8000_0010, '0);
        #1;
        chk1("cpu_rd_ram_re", ram_re, 1'b1);
        chk("cpu_rd_ram_addr", ram_addr, 64'h8000_0010);
        chk1("cpu_rd_mmio_re", mmio_re, 1'b0);
        cpu_exp_q.push_back(64'hDEAD_BEEF);
        tick();
        cpu_drive(1'b0, 1'b0, '0, '0);
        #1;
        chk_cpu_resp("cpu_rd_data");
        chk1("cpu_rd_no_done", m1_done, 1'b0);

        // Master-1 MMIO write with the CPU idle.
        m1_drive(1'b1, 1'b1, 64'h1000_0000, 64'h41);
        #1;
        chk1("m1w_ready_t", m1_ready, 1'b1);
        tick();
        m1_drive(1'b0, 1'b0, '0, '0);
        #1;
        chk1("m1w_ready_t1", m1_ready, 1'b0);
        chk1("m1w_mmio_we", mmio_we, 1'b1);
        chk("m1w_mmio_addr", mmio_addr, 64'h1000_0000);
        chk("m1w_mmio_wdata", mmio_wdata, 64'h41);
        chk1("m1w_ram_we", ram_we, 1'b0);
        chk1("m1w_done_t1", m1_done, 1'b0);
        tick();
        chk1("m1w_done_t2", m1_done, 1'b1);
        chk1("m1w_err_t2", m1_err, 1'b0);
        chk1("m1w_ready_t2", m1_ready, 1'b1);
        tick();
        chk1("m1w_done_t3", m1_done, 1'b0);

        // Master-1 read-back of the written MMIO word.
        m1_drive(1'b1, 1'b0, 64'h1000_0000, '0);
        tick();
        m1_drive(1'b0, 1'b0, '0, '0);
        #1;
        chk1("m1r_mmio_re", mmio_re, 1'b1);
        m1_exp_q.push_back(64'h41);
        tick();
        chk_m1_resp("m1r_readback");

        // Held master-1 RAM read while the CPU reads MMIO for 5 cycles.
        m1_drive(1'b1, 1'b0, 64'h8000_0100, '0);
        tick();
        m1_drive(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            cpu_drive(1'b1, 1'b0, 64'h1000_0008 + 64'(8 * i), '0);
            #1;
            chk1($sformatf("hold_ram_re%0d", i), ram_re, 1'b0);
            chk1($sformatf("hold_mmio_re%0d", i), mmio_re, 1'b1);
            chk1($sformatf("hold_ready%0d", i), m1_ready, 1'b0);
            if (i > 0) chk_cpu_resp($sformatf("hold_cpu_rd%0d", i - 1));
            cpu_exp_q.push_back(mmio_read(64'h1000_0008 + 64'(8 * i)));
            tick();
        end
        cpu_drive(1'b0, 1'b0, '0, '0);
        #1;
        chk_cpu_resp("hold_cpu_rd4");
        chk1("hold_issue_ram_re", ram_re, 1'b1);
        chk("hold_issue_addr", ram_addr, 64'h8000_0100);
        chk1("hold_issue_no_done", m1_done, 1'b0);
`ifdef ARB_STATS_EN
        chk("hold_wait_cnt", 64'(m1_wait_cnt), 64'd5);
`endif
        m1_exp_q.push_back(ram_read(64'h8000_0100));
        tick();
        chk_m1_resp("hold_m1_rd");
        chk1("hold_ready_after", m1_ready, 1'b1);

        // Interleave: master-1 RAM read issued at t, CPU MMIO read at t+1.
        m1_drive(1'b1, 1'b0, 64'h8000_0200, '0);
        tick();
        m1_drive(1'b0, 1'b0, '0, '0);
        #1;
        chk1("il_ram_re_t", ram_re, 1'b1);
        chk("il_ram_addr_t", ram_addr, 64'h8000_0200);
        m1_exp_q.push_back(ram_read(64'h8000_0200));
        tick();
        cpu_drive(1'b1, 1'b0, 64'h1000_0010, '0);
        #1;
        chk1("il_mmio_re_t1", mmio_re, 1'b1);
        chk1("il_ram_re_t1", ram_re, 1'b0);
        chk_m1_resp("il_m1_rd_t1");
        chk("il_cpu_rdata_t1", cpu_rdata, 64'h0);
        cpu_exp_q.push_back(mmio_read(64'h1000_0010));
        tick();
        cpu_drive(1'b0, 1'b0, '0, '0);
        #1;
        chk_cpu_resp("il_cpu_rd_t2");
        chk1("il_done_t2", m1_done, 1'b0);
        chk("il_m1_rdata_t2", m1_rdata, 64'h0);

        // Unmapped master-1 read, then unmapped CPU read.
        m1_drive(1'b1, 1'b0, 64'h0, '0);
        tick();
        m1_drive(1'b0, 1'b0, '0, '0);
        #1;
        chk("um_m1_strobes", 64'(strobes()), 64'h0);
        tick();
        chk1("um_m1_done", m1_done, 1'b1);
        chk1("um_m1_err", m1_err, 1'b1);
        chk("um_m1_rdata", m1_rdata, 64'h0);
        cpu_drive(1'b1, 1'b0, 64'h0, '0);
        #1;
        chk("um_cpu_strobes", 64'(strobes()), 64'h0);
        tick();
        cpu_drive(1'b0, 1'b0, '0, '0);
        #1;
        chk("um_cpu_rdata", cpu_rdata, 64'h0);
        chk1("um_cpu_no_err", m1_err, 1'b0);

        // Decode window edges via CPU reads.
        for (int i = 0; i < 7; i++) begin
            cpu_drive(1'b1, 1'b0, bnd_addr[i], '0);
            #1;
            chk($sformatf("bnd_strobes%0d", i), 64'(strobes()), 64'(bnd_exp[i]));
            if (bnd_exp[i][2])      cpu_exp_q.push_back(ram_read(bnd_addr[i]));
            else if (bnd_exp[i][0]) cpu_exp_q.push_back(mmio_read(bnd_addr[i]));
            else                    cpu_exp_q.push_back(64'h0);
            tick();
            cpu_drive(1'b0, 1'b0, '0, '0);
            #1;
            chk_cpu_resp($sformatf("bnd_rdata%0d", i));
        end

        // CPU we and re together is a write.
        cpu_drive(1'b1, 1'b1, 64'h8000_0300, 64'h77);
        #1;
        chk("wr_re_strobes", 64'(strobes()), 64'h8);
        chk("wr_re_wdata", ram_wdata, 64'h77);
        tick();
        cpu_drive(1'b1, 1'b0, 64'h8000_0300, '0);
        cpu_exp_q.push_back(64'h77);
        tick();
        cpu_drive(1'b0, 1'b0, '0, '0);
        #1;
        chk_cpu_resp("wr_re_readback");

        // Reset while a master-1 write is held behind a CPU access.
        m1_drive(1'b1, 1'b1, 64'h8000_0400, 64'h99);
        tick();
        m1_drive(1'b0, 1'b0, '0, '0);
        cpu_drive(1'b1, 1'b0, 64'h1000_0008, '0);
        #1;
        chk1("mid_ready_held", m1_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk1("mid_rst_ready", m1_ready, 1'b1);
        chk("mid_rst_strobes", 64'(strobes()), 64'h0);
        chk1("mid_rst_done", m1_done, 1'b0);
`ifdef ARB_STATS_EN
        chk("mid_rst_wait_cnt", 64'(m1_wait_cnt), 64'd0);
`endif
        tick();
        cpu_drive(1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        #1;
        chk1("post_rst_ready", m1_ready, 1'b1);
        chk1("post_rst_ram_we", ram_we, 1'b0);
        tick();
        chk1("post_rst_done", m1_done, 1'b0);
        cpu_drive(1'b1, 1'b0, 64'h8000_0400, '0);
        cpu_exp_q.push_back(ram_read(64'h8000_0400));
        tick();
        cpu_drive(1'b0, 1'b0, '0, '0);
        #1;
        chk_cpu_resp("post_rst_not_written");

        chk("sb_cpu_empty", 64'(cpu_exp_q.size()), 64'd0);
        chk("sb_m1_empty", 64'(m1_exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion expected finish before time 100000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single core memory bus between two masters and decodes each access to one of two slaves.
- Master 0 is the CPU; it never stalls and always has absolute priority.
- Master 1 is a DMA/loader port with a req/ready handshake; its requests are buffered and issued only in cycles when the CPU is idle.
- Sits between the core, the RAM block and the MMIO (UART/peripheral) block; read latency to both masters is preserved at 1 cycle.

Parameters:
- RAM_BASE, 64'h0000_0000_8000_0000, RAM region start address.
- RAM_SIZE, 64'h0000_0000_0010_0000, RAM region size in bytes.
- MMIO_BASE, 64'h0000_0000_1000_0000, MMIO region start address.
- MMIO_SIZE, 64'h0000_0000_0000_1000, MMIO region size in bytes.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- cpu_addr  input  64  CPU bus address
- cpu_wdata  input  64  CPU write data
- cpu_we  input  1  CPU write enable
- cpu_re  input  1  CPU read enable
- cpu_rdata  output  64  read data to CPU, valid the cycle after cpu_re
- m1_req  input  1  master-1 request valid
- m1_we  input  1  master-1 write (1) / read (0)
- m1_addr  input  64  master-1 address
- m1_wdata  input  64  master-1 write data
- m1_ready  output  1  master-1 request accepted when m1_req&m1_ready
- m1_done  output  1  one-cycle completion pulse
- m1_err  output  1  with m1_done: address unmapped
- m1_rdata  output  64  read data, valid with m1_done for reads
- ram_addr, ram_wdata  output  64  RAM address and write data
- ram_we, ram_re  output  1  RAM write and read strobes
- ram_rdata  input  64  RAM read data, 1-cycle latency
- mmio_addr, mmio_wdata  output  64  MMIO address and write data
- mmio_we, mmio_re  output  1  MMIO write and read strobes
- mmio_rdata  input  64  MMIO read data, 1-cycle latency

Behaviour:
- Reset values:
  - hold_valid=0; owner_q=NONE; m1_done=0; m1_err=0; m1_ready=1.
  - All slave strobes are 0.
  - cpu_rdata=0 and m1_rdata=0.
- Decode:
  - RAM hit when RAM_BASE <= addr < RAM_BASE+RAM_SIZE.
  - MMIO hit under the same rule on its own window.
  - Anything else is unmapped.
  - Comparisons are unsigned 64-bit; the region end must not wrap.
- CPU path (combinational, same cycle):
  - CPU is active when cpu_re|cpu_we.
  - CPU addr/wdata/strobes go to the decoded slave; the other slave's strobes are 0.
  - If cpu_we and cpu_re are both high, treat as a write and suppress re.
  - An unmapped CPU access drives no strobes.
- Holding register (one entry):
  - m1_ready = !hold_valid.
  - On m1_req&m1_ready, latch we/addr/wdata and set hold_valid at the next edge.
- Issue:
  - In any cycle with hold_valid=1 and the CPU idle, drive the held request to its decoded slave and clear hold_valid at the edge.
  - Result: at most one master-1 accept per 2 cycles.
  - While the CPU is active, the held request waits indefinitely; there is no timeout.
- Unmapped master-1 request:
  - Issues in the same CPU-idle slot but drives no strobes.
  - Next cycle: m1_done=1, m1_err=1, m1_rdata=0.
- Response routing:
  - owner_q is registered each cycle as one of {NONE, CPU_RAM, CPU_MMIO, CPU_UNMAPPED, M1_RAM, M1_MMIO, M1_UNMAPPED} for the access issued that cycle.
  - cpu_rdata: ram_rdata if owner_q=CPU_RAM, mmio_rdata if CPU_MMIO, else 0.
  - m1_rdata: selected the same way for M1_RAM/M1_MMIO, else 0.
  - m1_done is registered: high the cycle after any master-1 issue, for both reads and writes.
  - m1_err is high only for M1_UNMAPPED.
- Back-to-back accesses:
  - A CPU access may occur in the cycle after a master-1 issue.
  - Responses do not collide because each slave returns exactly 1 cycle after its strobe.
- Reset mid-operation:
  - A pending held request is dropped, with no m1_done.
  - Slave strobes deassert asynchronously.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined:
  - Adds output m1_wait_cnt (32 bits), reset 0.
  - Increments on every cycle where hold_valid=1 and the CPU is active.
  - Saturates at 32'hFFFF_FFFF; there is no clear other than reset.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- CPU read, cpu_re=1, cpu_addr=0x8000_0010:
  - same cycle: ram_re=1, ram_addr=0x8000_0010;
  - next cycle: cpu_rdata = ram_rdata (0xDEAD_BEEF).
  - m1_done stays 0.
- Master-1 write to 0x1000_0000, wdata 0x41, CPU idle:
  - accepted at cycle t, mmio_we=1 at t+1, m1_done=1 and m1_err=0 at t+2;
  - m1_ready is 0 only during t+1.
- Master-1 read held while the CPU issues reads for 5 consecutive cycles:
  - no ram_re from master 1 during those cycles;
  - issues in the first idle cycle, with m1_done one cycle later;
  - with ARB_STATS_EN, m1_wait_cnt=5.
- Interleave, master-1 RAM read at t, CPU MMIO read at t+1:
  - m1_rdata = ram_rdata at t+1;
  - cpu_rdata = mmio_rdata at t+2;
  - no cross-routing.
- Unmapped accesses:
  - master-1 read of 0x0: no strobes, then m1_done=1, m1_err=1, m1_rdata=0;
  - CPU read of 0x0: no strobes, cpu_rdata=0 next cycle.
- Reset asserted while hold_valid=1:
  - hold is cleared, no m1_done, m1_ready=1 after reset release.
